// File: rtl/alu_top_2.sv
// Multi-cycle 8-bit unsigned ALU: add, subtract, shift-add multiply and restoring divide.
// The FSM state is exported, and the result register holds its value until the next operation completes.
module alu_top_2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [1:0]  op,
    output logic [15:0] result,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOAD   = 3'b001,
        S_ADDSUB = 3'b010,
        S_MUL    = 3'b011,
        S_DIV    = 3'b100,
        S_DONE   = 3'b101
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;

    logic [15:0] mul_sum_s;
    logic [8:0]  div_shift_s;
    logic [8:0]  div_diff_s;
    logic        div_ge_s;
    logic [7:0]  div_rem_s;

    // Per-iteration datapath: one multiplier bit (LSB first) or one quotient bit (MSB first)
    always_comb begin
        mul_sum_s   = acc_q + (b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0);
        div_shift_s = {rem_q, a_q[3'd7 - cnt_q]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        div_rem_s   = div_ge_s ? div_diff_s[7:0] : div_shift_s[7:0];
    end

    // Next-state and next-register computation for the control FSM
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                a_d   = a;
                b_d   = b;
                op_d  = op;
                acc_d = 16'd0;
                rem_d = 8'd0;
                cnt_d = 3'd0;
                case (op)
                    2'b10:   state_d = S_MUL;
                    2'b11:   state_d = S_DIV;
                    default: state_d = S_ADDSUB;
                endcase
            end
            S_ADDSUB: begin
                if (op_q == 2'b00) begin
                    result_d = {7'd0, ({1'b0, a_q} + {1'b0, b_q})};
                end else begin
                    result_d = {8'd0, a_q} - {8'd0, b_q};
                end
                state_d = S_DONE;
            end
            S_MUL: begin
                acc_d = mul_sum_s;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = mul_sum_s;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_MUL;
                end
            end
            S_DIV: begin
                // Divide by zero short-circuits with an all-ones quotient
                if (b_q == 8'd0) begin
                    result_d = {a_q, 8'hFF};
                    state_d  = S_DONE;
                end else begin
                    rem_d = div_rem_s;
                    acc_d = {acc_q[14:0], div_ge_s};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_d = {div_rem_s, acc_q[6:0], div_ge_s};
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_DIV;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            op_q     <= 2'd0;
            acc_q    <= 16'd0;
            rem_q    <= 8'd0;
            cnt_q    <= 3'd0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign state  = state_q;

endmodule

// File: tb/tb_alu_top_2.sv
// Directed bench for alu_top_2: expected results are queued at launch and compared on return to IDLE.
module tb_alu_top_2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] result;
    logic [2:0]  state;

    int          total;
    int          bad;
    logic [15:0] sb_q[$];
    logic [15:0] dropped;

    alu_top_2 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int edges);
        edges = 1;
        while (state !== 3'b000 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                          input logic [15:0] exp, input int lat, input string tag);
        int edges;
        @(negedge clk);
        a = ia; b = ib; op = iop; start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_load"}, {13'd0, state}, 16'h0001);
        wait_idle(edges);
        check({tag, "_lat"}, 16'(edges), 16'(lat));
        check({tag, "_res"}, result, sb_q.pop_front());
    endtask

    initial begin
        int edges;
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; op = 2'd0;
        #2;
        check("rst_state", {13'd0, state}, 16'h0000);
        check("rst_result", result, 16'h0000);
        #8 rst = 1'b1;

        run_op(8'd10,  8'd5,   2'b00, 16'd15,   4,  "add");
        run_op(8'd15,  8'd8,   2'b01, 16'd7,    4,  "sub");
        run_op(8'd5,   8'd8,   2'b01, 16'hFFFD, 4,  "sub_neg");
        run_op(8'd3,   8'd4,   2'b10, 16'd12,   11, "mul");
        run_op(8'd255, 8'd255, 2'b10, 16'hFE01, 11, "mul_max");
        run_op(8'd200, 8'd7,   2'b11, 16'h041C, 11, "div");
        run_op(8'd9,   8'd0,   2'b11, 16'h09FF, 4,  "div_zero");
        run_op(8'd255, 8'd255, 2'b00, 16'h01FE, 4,  "add_carry");

        // Inputs changed and start pulsed while busy in MUL
        @(negedge clk);
        a = 8'd6; b = 8'd7; op = 2'b10; start = 1'b1;
        sb_q.push_back(16'd42);
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("busy_in_mul", {13'd0, state}, 16'h0003);
        @(negedge clk);
        a = 8'd1; b = 8'd1; op = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(edges);
        check("busy_res", result, sb_q.pop_front());
        repeat (3) begin @(posedge clk); #1; end
        check("busy_no_queue", {13'd0, state}, 16'h0000);
        check("busy_hold", result, 16'd42);

        // start held high across the return to IDLE relaunches
        @(negedge clk);
        a = 8'd20; b = 8'd30; op = 2'b00; start = 1'b1;
        sb_q.push_back(16'd50);
        sb_q.push_back(16'd50);
        @(posedge clk); #1;
        wait_idle(edges);
        check("b2b_lat", 16'(edges), 16'd4);
        check("b2b_res1", result, sb_q.pop_front());
        @(posedge clk); #1;
        check("b2b_relaunch", {13'd0, state}, 16'h0001);
        start = 1'b0;
        wait_idle(edges);
        check("b2b_res2", result, sb_q.pop_front());

        // Asynchronous reset while in MUL
        @(negedge clk);
        a = 8'd9; b = 8'd9; op = 2'b10; start = 1'b1;
        sb_q.push_back(16'd81);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_mul", {13'd0, state}, 16'h0003);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", {13'd0, state}, 16'h0000);
        check("async_rst_result", result, 16'h0000);
        dropped = sb_q.pop_front();
        @(negedge clk); rst = 1'b1;
        run_op(8'd7, 8'd6, 2'b10, 16'd42, 11, "mul_after_rst");

        check("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_top_2.md
Name:
alu_top_2

Overview:
- Multi-cycle 8-bit ALU with a start handshake.
- Operations: unsigned add, subtract, sequential shift-add multiply, and sequential restoring divide.
- The FSM state is exported for the bench and for control logic.
- Sits as a standalone datapath/control block; the result is held until the next operation completes.

Parameters:
- none (widths fixed: operands 8 bits, result 16 bits, state 3 bits)

Ports:
- clk    input   1   system clock, rising-edge active
- rst    input   1   reset, asynchronous, active-low (0 = reset)
- start  input   1   request; sampled only in IDLE
- a      input   8   operand A (unsigned)
- b      input   8   operand B (unsigned)
- op     input   2   00 ADD, 01 SUB, 10 MUL, 11 DIV
- result output  16  registered result of the last completed operation
- state  output  3   current FSM state encoding

Behaviour:
- Reset (rst=0, async): state=IDLE (000), result=0, internal accumulators/counters=0. Reset mid-operation aborts it; result returns to 0.
- State encoding:
  - IDLE 000
  - LOAD 001
  - ADDSUB 010
  - MUL 011
  - DIV 100
  - DONE 101
  - 110/111 unused; both go to IDLE on the next edge.
- IDLE: if start=1 at a rising edge, go to LOAD; else stay. start is ignored in every other state; no queuing.
- LOAD (1 cycle): latch a, b, op into internal registers. Input changes after this edge have no effect. Clear the accumulator and iteration counter. Next state by op: 00/01→ADDSUB, 10→MUL, 11→DIV.
- ADDSUB (1 cycle):
  - ADD: result_next = {7'b0, a+b as 9 bits}; carry lands in bit 8.
  - SUB: result_next = 16-bit two's complement of (a − b), i.e. zero-extend both operands to 16 bits and subtract.
  - Next state DONE.
- MUL (8 cycles): unsigned shift-add over a 16-bit product, one multiplier bit per cycle, LSB first. After 8 iterations the 16-bit product is final. Next state DONE.
- DIV (8 cycles): unsigned restoring division, one quotient bit per cycle, MSB first.
  - Final result = {remainder[7:0], quotient[7:0]}.
  - b=0: result = {a, 8'hFF}. Division skips iterating and goes straight to DONE after 1 cycle.
- DONE (1 cycle): result register loads the computed value on the edge entering DONE; next state IDLE.
- result holds its value through IDLE and through the next operation until the next DONE entry.
- Latency, from the edge sampling start to the edge returning to IDLE:
  - ADD/SUB: 4 edges
  - MUL: 11 edges
  - DIV: 11 edges (b=0: 4)
- A start held high across the return to IDLE launches a new operation on the next edge. Back-to-back operations are therefore allowed, with one IDLE cycle between them.
- All outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Reset low for 10 ns, release; a=10, b=5, op=00, start pulsed 1 cycle → state leaves 000, returns to 000; result=15.
- a=15, b=8, op=01 → result=7. Then a=5, b=8, op=01 → result=16'hFFFD.
- a=3, b=4, op=10 → result=12. Then a=255, b=255, op=10 → result=65025 (16'hFE01), IDLE reached 11 edges after the start edge.
- a=200, b=7, op=11 → result=16'h041C (quotient 28, remainder 4). Then a=9, b=0, op=11 → result=16'h09FF.
- ADD 255+255 → result=510 (bit 8 set). Change a/b/op while in MUL → result unaffected; start pulsed while busy → ignored.
- Drive rst=0 mid-MUL (state=011) → state=000 and result=0 immediately, without waiting for a clock edge; a later op completes normally.
